// File: rtl/riscv_pkg.sv
// Shared RV32I integer-datapath types and constants.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int RIDX_W = $clog2(NREGS);

    typedef logic [RIDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xdata_t;

    // x0 is hard-wired to zero and never tracked as a producer target
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Latency: mask updates on the next rising edge; ready flags are combinational.
// Backpressure: none here; decode stalls itself while a ready flag is low.
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS  = riscv_pkg::NREGS,
    parameter int AWIDTH = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_en,
    input  logic [AWIDTH-1:0] issue_rd,
    input  logic              wb_en,
    input  logic [AWIDTH-1:0] wb_rd,
    input  logic [AWIDTH-1:0] rs1,
    input  logic [AWIDTH-1:0] rs2,
    output logic [NREGS-1:0]  pending,
    output logic              porta_ready,
    output logic              portb_ready
);

    localparam logic [AWIDTH-1:0] ZERO_IDX = AWIDTH'(REG_ZERO);
    localparam bit                FWD      = (BYPASS != 0);

    logic             set_vld;
    logic             clr_vld;
    logic [NREGS-1:0] pending_nxt;

    // Next mask: clear first, then set, so a same-index issue (newer producer) wins
    always_comb begin
        set_vld     = issue_en && (issue_rd != ZERO_IDX);
        clr_vld     = wb_en && (wb_rd != ZERO_IDX);
        pending_nxt = pending;
        if (clr_vld) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (set_vld) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Mask register; reset discards every in-flight producer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // A port is ready when its source is x0, not outstanding, or being forwarded this cycle
    always_comb begin
        porta_ready = (rs1 == ZERO_IDX) || !pending[rs1] || (FWD && wb_en && (wb_rd == rs1));
        portb_ready = (rs2 == ZERO_IDX) || !pending[rs2] || (FWD && wb_en && (wb_rd == rs2));
    end

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write integer register file with pending-write scoreboard and optional write bypass.
// Latency: reads combinational (zero cycles); writes visible the cycle after presentation.
// Backpressure: none; ready flags tell decode when a read operand is not yet current.
module regfile_sb
    import riscv_pkg::*;
#(
    parameter int DWIDTH = XLEN,
    parameter int NREGS  = riscv_pkg::NREGS,
    parameter int AWIDTH = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] rs1,
    input  logic [AWIDTH-1:0] rs2,
    output logic [DWIDTH-1:0] porta,
    output logic [DWIDTH-1:0] portb,
    output logic              porta_ready,
    output logic              portb_ready,
    input  logic              issue_en,
    input  logic [AWIDTH-1:0] issue_rd,
    input  logic              RegWen,
    input  logic [AWIDTH-1:0] rd,
    input  logic [DWIDTH-1:0] writedata,
    output logic [NREGS-1:0]  pending
);

    localparam logic [AWIDTH-1:0] ZERO_IDX = AWIDTH'(REG_ZERO);
    localparam bit                FWD      = (BYPASS != 0);

    // Flop-based storage: the asynchronous clear rules out RAM inference
    logic [NREGS-1:0][DWIDTH-1:0] regs;
    logic                         wr_vld;

    assign wr_vld = RegWen && (rd != ZERO_IDX);

    // Write port; x0 is never written so its entry stays at the reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_vld) begin
            regs[rd] <= writedata;
        end
    end

    // Read muxes: stored value, overridden by same-cycle writeback, forced to zero for x0
    always_comb begin
        porta = regs[rs1];
        portb = regs[rs2];
        if (FWD && wr_vld && (rd == rs1)) begin
            porta = writedata;
        end
        if (FWD && wr_vld && (rd == rs2)) begin
            portb = writedata;
        end
        if (rs1 == ZERO_IDX) begin
            porta = '0;
        end
        if (rs2 == ZERO_IDX) begin
            portb = '0;
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .AWIDTH (AWIDTH),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .wb_en       (RegWen),
        .wb_rd       (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .pending     (pending),
        .porta_ready (porta_ready),
        .portb_ready (portb_ready)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one forwarding and one non-forwarding instance share the same stimulus.
// Latency: outputs compared mid-cycle against a behavioural model of registers and pending set.
// Backpressure: not applicable; ready flags are compared like data.
module tb_regfile_sb;
    import riscv_pkg::*;

    logic     clk   = 1'b0;
    logic     rst_n = 1'b0;
    reg_idx_t rs1 = '0, rs2 = '0, issue_rd = '0, wr_rd = '0;
    logic     issue_en = 1'b0, regwen = 1'b0;
    xdata_t   wdata = '0;

    xdata_t           porta_b, portb_b, porta_n, portb_n;
    logic             rdya_b, rdyb_b, rdya_n, rdyb_n;
    logic [NREGS-1:0] pend_b, pend_n;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: architectural register values plus set of outstanding destinations
    xdata_t           m_regs [NREGS];
    logic [NREGS-1:0] m_pend = '0;

    initial begin
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    end

    regfile_sb #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .porta(porta_b), .portb(portb_b), .porta_ready(rdya_b), .portb_ready(rdyb_b),
        .issue_en(issue_en), .issue_rd(issue_rd), .RegWen(regwen), .rd(wr_rd),
        .writedata(wdata), .pending(pend_b)
    );

    regfile_sb #(.BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .porta(porta_n), .portb(portb_n), .porta_ready(rdya_n), .portb_ready(rdyb_n),
        .issue_en(issue_en), .issue_rd(issue_rd), .RegWen(regwen), .rd(wr_rd),
        .writedata(wdata), .pending(pend_n)
    );

    initial forever #5 clk = ~clk;

    // Model update: a writeback retires its destination, an issue (applied after) marks one outstanding
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0;
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        end else begin
            if (regwen && wr_rd != 0) begin
                m_regs[wr_rd] = wdata;
                m_pend[wr_rd] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
    end

    function automatic xdata_t exp_data(input reg_idx_t idx, input bit fwd);
        if (idx == 0) return '0;
        if (fwd && regwen && wr_rd == idx) return wdata;
        return m_regs[idx];
    endfunction

    function automatic logic exp_rdy(input reg_idx_t idx, input bit fwd);
        return (idx == 0) || !m_pend[idx] || (fwd && regwen && wr_rd == idx);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("byp_porta", porta_b, exp_data(rs1, 1'b1));
            chk("byp_portb", portb_b, exp_data(rs2, 1'b1));
            chk("byp_rdya", 32'(rdya_b), 32'(exp_rdy(rs1, 1'b1)));
            chk("byp_rdyb", 32'(rdyb_b), 32'(exp_rdy(rs2, 1'b1)));
            chk("byp_pend", pend_b, m_pend);
            chk("nob_porta", porta_n, exp_data(rs1, 1'b0));
            chk("nob_portb", portb_n, exp_data(rs2, 1'b0));
            chk("nob_rdya", 32'(rdya_n), 32'(exp_rdy(rs1, 1'b0)));
            chk("nob_rdyb", 32'(rdyb_n), 32'(exp_rdy(rs2, 1'b0)));
            chk("nob_pend", pend_n, m_pend);
        end
    end

    task automatic drive(input logic ie, input reg_idx_t ird, input logic we, input reg_idx_t wrd,
                         input xdata_t wd, input reg_idx_t r1, input reg_idx_t r2);
        issue_en = ie; issue_rd = ird; regwen = we; wr_rd = wrd; wdata = wd; rs1 = r1; rs2 = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic reg_idx_t pick_idx();
        if ($urandom_range(0, 9) < 8) return reg_idx_t'($urandom_range(0, 7));
        return reg_idx_t'($urandom_range(0, NREGS - 1));
    endfunction

    initial begin
        reg_idx_t r1, r2, wrd;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_porta", porta_b, 32'h0);
        chk("rst_rdya", 32'(rdya_n), 32'h1);
        chk("rst_pend", pend_b, 32'h0);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        // Asynchronous reset with x5 written and pending
        drive(0, 0, 1, 5, 32'hDEADBEEF, 5, 5);
        step();
        drive(1, 5, 0, 0, 0, 5, 5);
        step();
        drive(0, 0, 0, 0, 0, 5, 5);
        @(negedge clk);
        chk("t1_pre_data", porta_n, 32'hDEADBEEF);
        chk("t1_pre_rdy", 32'(rdya_b), 32'h0);
        chk("t1_pre_pend", pend_b, 32'h0000_0020);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_data_b", porta_b, 32'h0);
        chk("t1_rst_data_n", portb_n, 32'h0);
        chk("t1_rst_rdy", 32'(rdya_b), 32'h1);
        chk("t1_rst_pend", pend_n, 32'h0);
        #1 rst_n = 1'b1;
        step();

        // x0 write and issue are ignored
        drive(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        @(negedge clk);
        chk("t2_fwd_x0", porta_b, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_porta", porta_n, 32'h0);
        chk("t2_pend", pend_b, 32'h0);

        // Issue x7, then writeback: forwarding vs non-forwarding
        step();
        drive(0, 0, 1, 7, 32'h55, 7, 0);
        step();
        drive(1, 7, 0, 0, 0, 7, 0);
        step();
        drive(0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        chk("t3_stall_b", 32'(rdya_b), 32'h0);
        chk("t3_stall_n", 32'(rdya_n), 32'h0);
        step();
        drive(0, 0, 1, 7, 32'h1234, 7, 0);
        @(negedge clk);
        chk("t3_fwd_data", porta_b, 32'h1234);
        chk("t3_fwd_rdy", 32'(rdya_b), 32'h1);
        chk("t4_old_data", porta_n, 32'h55);
        chk("t4_old_rdy", 32'(rdya_n), 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        chk("t3_after_data", porta_b, 32'h1234);
        chk("t4_after_data", porta_n, 32'h1234);
        chk("t4_after_rdy", 32'(rdya_n), 32'h1);
        chk("t3_after_pend", pend_b, 32'h0);

        // Same-index issue+writeback, then different-index issue+writeback
        step();
        drive(1, 4, 0, 0, 0, 0, 0);
        step();
        drive(1, 9, 1, 9, 32'hA5, 0, 0);
        step();
        drive(1, 3, 1, 4, 32'h44, 9, 4);
        @(negedge clk);
        chk("t5_data9", porta_n, 32'hA5);
        chk("t5_pend9", pend_n, 32'h0000_0210);
        step();
        drive(0, 0, 0, 0, 0, 3, 4);
        @(negedge clk);
        chk("t5_pend34", pend_b, 32'h0000_0208);
        chk("t5_rdy3", 32'(rdya_b), 32'h0);
        chk("t5_data4", portb_n, 32'h44);

        // Randomised traffic focused on a few registers so hazards are frequent
        for (int n = 0; n < 10000; n++) begin
            step();
            r1  = pick_idx();
            wrd = pick_idx();
            if ($urandom_range(0, 3) == 0) r1 = wrd;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : pick_idx();
            drive(logic'($urandom_range(0, 9) < 4), pick_idx(), logic'($urandom_range(0, 1)),
                  wrd, xdata_t'($urandom), r1, r2);
            if ($urandom_range(0, 2499) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
